// File: rtl/fan_state_ctrl_if.sv
// Button inputs and fan outputs of the fan state controller.
// master drives the buttons, slave is the controller.
interface fan_state_ctrl_if;
  logic       i_btnUp;
  logic       i_btnDown;
  logic       i_btnOff;
  logic [2:0] o_fanState;
  logic       o_pwm;

  modport master (
    output i_btnUp,
    output i_btnDown,
    output i_btnOff,
    input  o_fanState,
    input  o_pwm
  );

  modport slave (
    input  i_btnUp,
    input  i_btnDown,
    input  i_btnOff,
    output o_fanState,
    output o_pwm
  );
endinterface

// File: rtl/fan_state_ctrl.sv
// Fan speed FSM (OFF, 1..4) from push buttons, plus speed PWM.
// Optional idle auto-off enabled by defining FAN_AUTO_OFF_EN.
module fan_state_ctrl #(
  parameter int PWM_PERIOD     = 100,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input logic             i_clk,
  input logic             i_reset,
  fan_state_ctrl_if.slave bus
);

  localparam int CW = $clog2(PWM_PERIOD);
  localparam int DW = CW + 1;
  localparam int QTR = PWM_PERIOD / 4;

  if ((PWM_PERIOD < 4) || (PWM_PERIOD % 4 != 0)) begin : g_bad_period
    $error("PWM_PERIOD must be a multiple of 4, >= 4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_1   = 3'd1,
    S_2   = 3'd2,
    S_3   = 3'd3,
    S_4   = 3'd4
  } state_t;

  // bit 0 up, bit 1 down, bit 2 off
  logic [2:0] btn;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] prev_q;
  logic [2:0] press;

  state_t state_q;
  state_t state_d;
  logic   timeout_hit;

  logic [CW-1:0] cnt_q;
  logic [DW-1:0] duty_q;
  logic [DW-1:0] duty_next;
  logic          wrap;
  logic          pwm_q;

  assign btn   = {bus.i_btnOff, bus.i_btnDown, bus.i_btnUp};
  assign press = sync2_q & ~prev_q;

  // Synchronise raw button levels and keep one stage for edge detect
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

`ifdef FAN_AUTO_OFF_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IW-1:0] idle_q;

  assign timeout_hit = (state_q != S_OFF) &&
                       (idle_q == IW'(TIMEOUT_CYCLES - 1));

  // Idle time since last press; restarts on press, OFF or expiry
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idle_q <= '0;
    end else if ((|press) || (state_q == S_OFF) || timeout_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Fan state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: Off beats Down beats Up; a press beats the idle timeout
  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      press[2]: state_d = S_OFF;
      press[1]: begin
        if (state_q != S_OFF) state_d = state_t'(state_q - 3'd1);
      end
      press[0]: begin
        if (state_q != S_4) state_d = state_t'(state_q + 3'd1);
      end
      default: begin
        if (timeout_hit) state_d = S_OFF;
      end
    endcase
  end

  assign wrap      = (cnt_q == CW'(PWM_PERIOD - 1));
  assign duty_next = DW'(state_q) * DW'(QTR);

  // Free-running PWM with duty latched only at period end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      if (wrap) duty_q <= duty_next;
      pwm_q <= ({1'b0, cnt_q} < duty_q);
    end
  end

  assign bus.o_fanState = state_q;
  assign bus.o_pwm      = pwm_q;

endmodule

// File: tb/tb_fan_state_ctrl.sv
// Randomised + directed bench for fan_state_ctrl with a
// delay-line/arithmetic reference model and output scoreboard.
module tb_fan_state_ctrl;

  localparam int P = 8;
  localparam int T = 50;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    int st;
    int pwm;
  } exp_t;

  exp_t exp_q[$];

  fan_state_ctrl_if bus ();

  fan_state_ctrl #(
    .PWM_PERIOD     (P),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: button levels pass a 2-edge delay line and
  // a rising level counts as one press; PWM from plain arithmetic.
  logic [2:0] hu;
  logic [2:0] hd;
  logic [2:0] ho;
  int m_state;
  int m_cnt;
  int m_duty;
  int m_pwm;
  int m_idle;

  always @(posedge clk) begin
    exp_t e;
    logic pu;
    logic pd;
    logic po;
    logic tmo;
    int   nxt;
    if (rst) begin
      hu = '0;
      hd = '0;
      ho = '0;
      m_state = 0;
      m_cnt = 0;
      m_duty = 0;
      m_pwm = 0;
      m_idle = 0;
    end else begin
      pu = hu[1] & ~hu[2];
      pd = hd[1] & ~hd[2];
      po = ho[1] & ~ho[2];
      m_pwm = (m_cnt < m_duty) ? 1 : 0;
      if (m_cnt == P - 1) m_duty = m_state * (P / 4);
      m_cnt = (m_cnt + 1) % P;
      tmo = 1'b0;
`ifdef FAN_AUTO_OFF_EN
      tmo = (m_state != 0) && (m_idle == T - 1);
`endif
      nxt = m_state;
      if (po) nxt = 0;
      else if (pd) nxt = (m_state > 0) ? m_state - 1 : 0;
      else if (pu) nxt = (m_state < 4) ? m_state + 1 : 4;
      else if (tmo) nxt = 0;
      if (pu || pd || po || m_state == 0 || tmo) m_idle = 0;
      else m_idle = m_idle + 1;
      m_state = nxt;
      hu = {hu[1:0], bus.i_btnUp};
      hd = {hd[1:0], bus.i_btnDown};
      ho = {ho[1:0], bus.i_btnOff};
    end
    e.st = m_state;
    e.pwm = m_pwm;
    exp_q.push_back(e);
  end

  // Monitor: compare the registered outputs after every edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (int'(bus.o_fanState) != e.st) begin
        errors++;
        $display("FAIL sb_state t=%0t act=%0d exp=%0d",
                 $time, bus.o_fanState, e.st);
      end
      checks++;
      if (int'(bus.o_pwm) != e.pwm) begin
        errors++;
        $display("FAIL sb_pwm t=%0t act=%0d exp=%0d",
                 $time, bus.o_pwm, e.pwm);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d, input logic o);
    @(negedge clk);
    bus.i_btnUp = u;
    bus.i_btnDown = d;
    bus.i_btnOff = o;
    @(negedge clk);
    bus.i_btnUp = 1'b0;
    bus.i_btnDown = 1'b0;
    bus.i_btnOff = 1'b0;
    tick(3);
  endtask

  task automatic pwm_window(input string nm, input int exp);
    int hi;
    hi = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      hi += int'(bus.o_pwm);
    end
    chk(nm, hi, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_btnUp = 1'b0;
    bus.i_btnDown = 1'b0;
    bus.i_btnOff = 1'b0;
    tick(2);
    chk("rst_state", int'(bus.o_fanState), 0);
    chk("rst_pwm", int'(bus.o_pwm), 0);
    rst = 1'b0;

    bus.i_btnUp = 1'b1;
    tick(10);
    bus.i_btnUp = 1'b0;
    tick(3);
    chk("held_up_once", int'(bus.o_fanState), 1);

    press(1, 0, 0);
    press(1, 0, 0);
    chk("three_ups", int'(bus.o_fanState), 3);
    tick(2 * P);
    pwm_window("duty_s3", 6);

    repeat (6) press(1, 0, 0);
    chk("sat_s4", int'(bus.o_fanState), 4);
    tick(2 * P);
    pwm_window("duty_s4", P);
    repeat (5) press(0, 1, 0);
    chk("floor_s0", int'(bus.o_fanState), 0);
    tick(2 * P);
    pwm_window("duty_s0", 0);

    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 1, 0);
    chk("down_beats_up", int'(bus.o_fanState), 1);
    press(1, 0, 0);
    press(1, 0, 1);
    chk("off_beats_up", int'(bus.o_fanState), 0);
    press(0, 1, 0);
    chk("down_at_off", int'(bus.o_fanState), 0);

    repeat (3) press(1, 0, 0);
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state", int'(bus.o_fanState), 0);
    chk("midrst_pwm", int'(bus.o_pwm), 0);

    press(1, 0, 0);
    press(1, 0, 0);
`ifdef FAN_AUTO_OFF_EN
    tick(T + 10);
    chk("auto_off", int'(bus.o_fanState), 0);
    press(1, 0, 0);
    press(1, 0, 0);
    tick(T - 6);
    press(1, 0, 0);
    tick(40);
    chk("idle_restart", int'(bus.o_fanState), 3);
    tick(12);
    chk("auto_off2", int'(bus.o_fanState), 0);
`else
    tick(200);
    chk("no_auto_off", int'(bus.o_fanState), 2);
`endif

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.i_btnUp = ($urandom_range(0, 2) == 0);
      bus.i_btnDown = ($urandom_range(0, 3) == 0);
      bus.i_btnOff = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.i_btnUp = 1'b0;
    bus.i_btnDown = 1'b0;
    bus.i_btnOff = 1'b0;
    tick(4);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
